mux_arbiter4: RTL

Round-robin arbiter that shares one 32-bit datapath among four requesters by driving the select pair of a 4:1 word selector. It sits between the four sources (for example IF fetch, LW/SW data port, DMA and debug) and the shared memory/bus port. It issues one-hot grants, holds ownership for a multi-beat transfer and hands over without idle cycles. It also exposes the selected word and a valid flag to the downstream port.

---
 rtl/mux_arbiter4_pkg.sv | 14 +
 rtl/mux_arbiter4_if.sv | 20 ++
 rtl/mux4.sv | 12 +
 rtl/mux_arbiter4_rr_pick4.sv | 30 +++
 rtl/mux_arbiter4.sv | 85 ++++++++
 5 files changed

// File: rtl/mux_arbiter4_pkg.sv
// mux_arb_pkg: shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package mux_arb_pkg;
    localparam int N_REQ         = 4;
    localparam int DEF_MAX_BURST = 8;
    // Owner index to {c1,c2} select mapping: the select pair is simply the owner index.
    localparam logic [1:0] SEL_IN1 = 2'b00;
    localparam logic [1:0] SEL_IN2 = 2'b01;
    localparam logic [1:0] SEL_IN3 = 2'b10;
    localparam logic [1:0] SEL_IN4 = 2'b11;
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_t;
    function automatic logic [N_REQ-1:0] idx2oh(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/mux_arbiter4_if.sv
// mux_arbiter4_if: requester/arbiter bundle.
//   req, last        per-requester request level and final-beat marker
//   data_in1..4      requester words
//   grant, c1, c2    registered one-hot owner and select pair
//   data_out         selected word; data_valid = a beat transfers; busy = grant active
//   slave modport = arbiter side, master modport = requester/bus side
interface mux_arbiter4_if #(parameter int DW = 32);
    logic [3:0]    req;
    logic [3:0]    last;
    logic [DW-1:0] data_in1, data_in2, data_in3, data_in4;
    logic [3:0]    grant;
    logic          c1, c2;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    modport slave (input req, last, data_in1, data_in2, data_in3, data_in4,
                   output grant, c1, c2, data_out, data_valid, busy);
    modport master (output req, last, data_in1, data_in2, data_in3, data_in4,
                    input grant, c1, c2, data_out, data_valid, busy);
endinterface

// File: rtl/mux4.sv
// MUX4: W-bit 4:1 word selector; {i_s1,i_s0} = 00 -> i_d0 ... 11 -> i_d3.
module MUX4 #(parameter int W = 32) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [W-1:0] i_d3,
    input  logic         i_s1,
    input  logic         i_s0,
    output logic [W-1:0] o_y
);
    assign o_y = i_s1 ? (i_s0 ? i_d3 : i_d2) : (i_s0 ? i_d1 : i_d0);
endmodule

// File: rtl/mux_arbiter4_rr_pick4.sv
// rr_pick4: combinational round-robin picker.
//   i_req   request vector        i_ptr   highest-priority index
//   i_excl  ignore index i_ptr-1 (the current owner, since the pointer sits one past it)
//   o_idx   winning index         o_found any eligible request present
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    input  logic       i_excl,
    output logic [1:0] o_idx,
    output logic       o_found
);
    logic [3:0] w_req;
    logic [1:0] w_t;
    always_comb begin
        w_req   = i_req & ~(i_excl ? idx2oh(i_ptr - 2'd1) : 4'd0);
        o_idx   = i_ptr;
        o_found = 1'b0;
        w_t     = i_ptr;
        // Scan from farthest to nearest so the nearest set bit is the one left standing.
        for (int k = 3; k >= 0; k--) begin
            w_t = i_ptr + 2'(k);
            if (w_req[w_t]) begin
                o_idx   = w_t;
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arbiter4.sv
// mux_arbiter4: round-robin owner of a shared DW-bit word path driving a 4:1 selector.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         mux_arbiter4_if.slave: req/last/data_in1..4 in; grant/c1/c2/data_out/data_valid/busy out
//   Optional ARB_BURST_LIMIT_EN: force a release after MAX_BURST beats of one grant.
module mux_arbiter4
    import mux_arb_pkg::*;
#(
    parameter int DW        = 32,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic           clk,
    input logic           rst_n,
    mux_arbiter4_if.slave bus
);
    arb_state_t r_state, w_next_state;
    logic [3:0] r_grant;
    logic       r_c1, r_c2;
    logic [1:0] r_ptr;
    logic [1:0] w_owner, w_idx;
    logic       w_busy, w_oreq, w_beat, w_limit, w_rel, w_found, w_load;
    assign w_owner = {r_c1, r_c2};
    assign w_busy  = (r_state == OWN);
    assign w_oreq  = bus.req[w_owner];
    assign w_beat  = w_busy & w_oreq;
`ifdef ARB_BURST_LIMIT_EN
    logic [7:0] r_cnt;
    assign w_limit = w_beat & (r_cnt == 8'(MAX_BURST - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (w_rel | w_load) ? 8'd0 : (w_beat ? r_cnt + 8'd1 : r_cnt);
    end
`else
    logic w_unused_max;
    assign w_unused_max = |32'(MAX_BURST);
    assign w_limit      = 1'b0;
`endif
    // An abandon (req dropped) releases without counting as a beat.
    assign w_rel = w_busy & (~w_oreq | (w_beat & bus.last[w_owner]) | w_limit);
    // While owning, the pointer is owner+1, so excluding ptr-1 leaves only the other requesters.
    rr_pick4 u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .i_excl  (w_busy),
        .o_idx   (w_idx),
        .o_found (w_found)
    );
    assign w_load = (~w_busy | w_rel) & w_found;
    always_comb begin
        w_next_state = r_state;
        if (w_load)     w_next_state = OWN;
        else if (w_rel) w_next_state = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_c1    <= 1'b0;
            r_c2    <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_grant      <= idx2oh(w_idx);
                {r_c1, r_c2} <= w_idx;
                r_ptr        <= w_idx + 2'd1;
            end else if (w_rel) begin
                r_grant <= '0;
            end
        end
    end
    assign bus.grant      = r_grant;
    assign bus.c1         = r_c1;
    assign bus.c2         = r_c2;
    assign bus.busy       = w_busy;
    assign bus.data_valid = w_beat;
    MUX4 #(.W(DW)) u_mux (
        .i_d0 (bus.data_in1),
        .i_d1 (bus.data_in2),
        .i_d2 (bus.data_in3),
        .i_d3 (bus.data_in4),
        .i_s1 (r_c1),
        .i_s0 (r_c2),
        .o_y  (bus.data_out)
    );
endmodule
